// File: rtl/sram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sram_arb_pkg
// Shared types and constants for the SRAM access arbiter.
//   arb_state_t : arbiter phase (IDLE / CAPTURE / PAINT), encoded as on o_state
//   client_t    : identifies which client owns an access or a returning read
//   SRAM_WEN_*  : levels of the active-low SRAM write enable
// -----------------------------------------------------------------------------
package sram_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_PAINT   = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    CL_NONE = 2'd0,
    CL_DISP = 2'd1,
    CL_CAP  = 2'd2,
    CL_PNT  = 2'd3
  } client_t;

  localparam logic SRAM_WEN_WRITE = 1'b0;
  localparam logic SRAM_WEN_IDLE  = 1'b1;

  // True when the given client's access is a write. Capture always writes,
  // display always reads, painter follows its own we flag.
  function automatic logic client_is_write(client_t cl, logic pnt_we);
    logic w_wr;
    w_wr = 1'b0;
    case (cl)
      CL_CAP:  w_wr = 1'b1;
      CL_PNT:  w_wr = pnt_we;
      default: w_wr = 1'b0;
    endcase
    return w_wr;
  endfunction

endpackage

// File: rtl/sram_access_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_access_arbiter_if
// External SRAM pin bundle.
//   o_s_addr : word address driven to the SRAM
//   o_s_data : write data driven to the SRAM
//   o_s_wen  : write enable, active low
//   i_s_data : read data returned by the SRAM
// Modports: master = arbiter side, slave = SRAM / pad side.
// -----------------------------------------------------------------------------
interface sram_access_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);

  logic [ADDR_W-1:0] o_s_addr;
  logic [DATA_W-1:0] o_s_data;
  logic              o_s_wen;
  logic [DATA_W-1:0] i_s_data;

  modport master (
    output o_s_addr,
    output o_s_data,
    output o_s_wen,
    input  i_s_data
  );

  modport slave (
    input  o_s_addr,
    input  o_s_data,
    input  o_s_wen,
    output i_s_data
  );

endinterface

// File: rtl/sram_issue_pipe.sv
// -----------------------------------------------------------------------------
// sram_issue_pipe
// Registered SRAM pin stage plus the two-stage read-return pipeline.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_issue        : an access is granted this cycle
//   i_client       : owner of the granted access
//   i_we           : granted access is a write
//   i_addr/i_wdata : address / write data of the granted access
//   sram           : SRAM pins (master side)
//   o_disp_*       : display read data / valid
//   o_pnt_*        : painter read data / valid
// Grant at t -> pins at t+1 -> i_s_data captured at end of t+1 -> rvalid at t+2.
// -----------------------------------------------------------------------------
module sram_issue_pipe
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_issue,
  input  client_t               i_client,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [DATA_W-1:0]     i_wdata,
  sram_access_arbiter_if.master sram,
  output logic [DATA_W-1:0]     o_disp_rdata,
  output logic                  o_disp_rvalid,
  output logic [DATA_W-1:0]     o_pnt_rdata,
  output logic                  o_pnt_rvalid
);

  logic [ADDR_W-1:0] r_s_addr;
  logic [DATA_W-1:0] r_s_data;
  logic              r_s_wen;
  // Owner of the read currently on the pins (stage 1 of the return path).
  client_t           r_rd_id;

  // Address and data are held across idle cycles; only wen drops back to idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s_addr <= '0;
      r_s_data <= '0;
      r_s_wen  <= SRAM_WEN_IDLE;
      r_rd_id  <= CL_NONE;
    end else begin
      r_s_wen <= SRAM_WEN_IDLE;
      r_rd_id <= CL_NONE;
      if (i_issue) begin
        r_s_addr <= i_addr;
        if (i_we) begin
          r_s_wen  <= SRAM_WEN_WRITE;
          r_s_data <= i_wdata;
        end else begin
          r_rd_id  <= i_client;
        end
      end
    end
  end

  assign sram.o_s_addr = r_s_addr;
  assign sram.o_s_data = r_s_data;
  assign sram.o_s_wen  = r_s_wen;

  // Stage 2: one return channel per reading client (0 = display, 1 = painter).
  // The id travels with the read, so a phase change never misroutes data.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ret
      localparam client_t OWNER = (gi == 0) ? CL_DISP : CL_PNT;
      logic              r_rvalid;
      logic [DATA_W-1:0] r_rdata;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_rvalid <= 1'b0;
          r_rdata  <= '0;
        end else begin
          r_rvalid <= (r_rd_id == OWNER);
          if (r_rd_id == OWNER) begin
            r_rdata <= sram.i_s_data;
          end
        end
      end
    end
  endgenerate

  assign o_disp_rvalid = g_ret[0].r_rvalid;
  assign o_disp_rdata  = g_ret[0].r_rdata;
  assign o_pnt_rvalid  = g_ret[1].r_rvalid;
  assign o_pnt_rdata   = g_ret[1].r_rdata;

endmodule

// File: rtl/sram_access_arbiter.sv
// -----------------------------------------------------------------------------
// sram_access_arbiter
// Shares one single-port SRAM between display read-back, the frame capture
// writer and the painter engine; sequences IDLE -> CAPTURE -> PAINT.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_start_cap, i_stop     : phase control pulses (start wins if both)
//   o_cap_done, o_state     : capture-complete pulse, current phase
//   i_disp_* / o_disp_*     : display read client
//   i_cap_* / o_cap_gnt     : capture write client
//   i_pnt_* / o_pnt_*       : painter read/write client
//   sram                    : registered SRAM pins (master side)
// One access is granted per cycle; a read directly after a write is delayed
// one cycle for bus turnaround. The painter is forced through after
// STARVE_MAX consecutive denied cycles (0 disables).
// -----------------------------------------------------------------------------
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int CAP_WORDS  = 105000,
  parameter int STARVE_MAX = 15
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start_cap,
  input  logic                  i_stop,
  output logic                  o_cap_done,
  output logic [1:0]            o_state,
  input  logic                  i_disp_req,
  input  logic [ADDR_W-1:0]     i_disp_addr,
  output logic                  o_disp_gnt,
  output logic [DATA_W-1:0]     o_disp_rdata,
  output logic                  o_disp_rvalid,
  input  logic                  i_cap_req,
  input  logic [ADDR_W-1:0]     i_cap_addr,
  input  logic [DATA_W-1:0]     i_cap_wdata,
  output logic                  o_cap_gnt,
  input  logic                  i_pnt_req,
  input  logic                  i_pnt_we,
  input  logic [ADDR_W-1:0]     i_pnt_addr,
  input  logic [DATA_W-1:0]     i_pnt_wdata,
  output logic                  o_pnt_gnt,
  output logic [DATA_W-1:0]     o_pnt_rdata,
  output logic                  o_pnt_rvalid,
  sram_access_arbiter_if.master sram
);

  localparam int                STARVE_W   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] CAP_LAST   = ADDR_W'(CAP_WORDS - 1);

  arb_state_t          r_state, w_state_next;
  logic [ADDR_W-1:0]   r_cap_cnt, w_cap_cnt_next;
  logic [STARVE_W-1:0] r_starve_cnt, w_starve_cnt_next;
  logic                r_last_wr, w_last_wr_next;

  client_t             w_cand;
  client_t             w_gnt_cl;
  logic                w_cand_we;
  logic                w_bubble;
  logic                w_issue;
  logic                w_starve_force;
  logic                w_cap_last;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;

  // ---------------------------------------------------------------------------
  // Candidate selection and grant
  // ---------------------------------------------------------------------------
  assign w_starve_force = (STARVE_MAX > 0) && (r_state == S_PAINT) &&
                          i_pnt_req && (r_starve_cnt == STARVE_LIM);

  always_comb begin
    w_cand = CL_NONE;
    case (r_state)
      S_IDLE: begin
        if (i_disp_req) w_cand = CL_DISP;
      end
      S_CAPTURE: begin
        if (i_disp_req)     w_cand = CL_DISP;
        else if (i_cap_req) w_cand = CL_CAP;
      end
      S_PAINT: begin
        if (w_starve_force) w_cand = CL_PNT;
        else if (i_disp_req) w_cand = CL_DISP;
        else if (i_pnt_req)  w_cand = CL_PNT;
      end
      default: w_cand = CL_NONE;
    endcase
  end

  assign w_cand_we = client_is_write(w_cand, i_pnt_we);
  // A read right after an issued write waits one cycle; the requester keeps
  // its request up and is re-evaluated next cycle.
  assign w_bubble  = r_last_wr && (w_cand != CL_NONE) && !w_cand_we;
  // Grants are held off while reset is asserted so every output sits at its
  // reset value during reset.
  assign w_issue   = i_rst_n && (w_cand != CL_NONE) && !w_bubble;
  assign w_gnt_cl  = w_issue ? w_cand : CL_NONE;

  assign o_disp_gnt = (w_gnt_cl == CL_DISP);
  assign o_cap_gnt  = (w_gnt_cl == CL_CAP);
  assign o_pnt_gnt  = (w_gnt_cl == CL_PNT);

  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    case (w_cand)
      CL_DISP: w_addr = i_disp_addr;
      CL_CAP: begin
        w_addr  = i_cap_addr;
        w_wdata = i_cap_wdata;
      end
      CL_PNT: begin
        w_addr  = i_pnt_addr;
        w_wdata = i_pnt_wdata;
      end
      default: begin
        w_addr  = '0;
        w_wdata = '0;
      end
    endcase
  end

  assign w_cap_last = (w_gnt_cl == CL_CAP) && (r_cap_cnt == CAP_LAST);
  assign o_cap_done = w_cap_last;
  assign o_state    = r_state;

  // ---------------------------------------------------------------------------
  // Phase FSM and counters
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_cap_cnt_next = r_cap_cnt;

    if (w_gnt_cl == CL_CAP) begin
      w_cap_cnt_next = w_cap_last ? '0 : (r_cap_cnt + ADDR_W'(1));
    end

    case (r_state)
      S_IDLE: begin
        if (i_start_cap) begin
          w_state_next   = S_CAPTURE;
          w_cap_cnt_next = '0;
        end
      end
      S_CAPTURE: begin
        // A start pulse during capture restarts the frame count.
        if (i_start_cap) begin
          w_state_next   = S_CAPTURE;
          w_cap_cnt_next = '0;
        end else if (i_stop) begin
          w_state_next   = S_IDLE;
          w_cap_cnt_next = '0;
        end else if (w_cap_last) begin
          w_state_next   = S_PAINT;
        end
      end
      S_PAINT: begin
        if (i_start_cap) begin
          w_state_next   = S_CAPTURE;
          w_cap_cnt_next = '0;
        end else if (i_stop) begin
          w_state_next   = S_IDLE;
        end
      end
      default: begin
        w_state_next   = S_IDLE;
        w_cap_cnt_next = '0;
      end
    endcase
  end

  // Starvation only accrues while the painter is eligible (PAINT). The count
  // saturates so a forced grant lost to a turnaround bubble is retried.
  always_comb begin
    w_starve_cnt_next = '0;
    if ((r_state == S_PAINT) && i_pnt_req && (w_gnt_cl != CL_PNT)) begin
      if (r_starve_cnt != STARVE_LIM) begin
        w_starve_cnt_next = r_starve_cnt + STARVE_W'(1);
      end else begin
        w_starve_cnt_next = r_starve_cnt;
      end
    end
  end

  assign w_last_wr_next = w_issue && w_cand_we;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_cap_cnt    <= '0;
      r_starve_cnt <= '0;
      r_last_wr    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cap_cnt    <= w_cap_cnt_next;
      r_starve_cnt <= w_starve_cnt_next;
      r_last_wr    <= w_last_wr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Pin stage and read return
  // ---------------------------------------------------------------------------
  sram_issue_pipe #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pipe (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_issue       (w_issue),
    .i_client      (w_cand),
    .i_we          (w_cand_we),
    .i_addr        (w_addr),
    .i_wdata       (w_wdata),
    .sram          (sram),
    .o_disp_rdata  (o_disp_rdata),
    .o_disp_rvalid (o_disp_rvalid),
    .o_pnt_rdata   (o_pnt_rdata),
    .o_pnt_rvalid  (o_pnt_rvalid)
  );

endmodule

// File: tb/tb_sram_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_access_arbiter
// Directed bench for sram_access_arbiter with CAP_WORDS=4, STARVE_MAX=3.
// A small SRAM model (256 words, preloaded during reset) answers the pins.
// Inputs are driven on the falling edge and outputs compared 1 ns later.
// -----------------------------------------------------------------------------
module tb_sram_access_arbiter;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;

  logic              i_clk;
  logic              i_rst_n;
  logic              i_start_cap, i_stop;
  logic              o_cap_done;
  logic [1:0]        o_state;
  logic              i_disp_req;
  logic [ADDR_W-1:0] i_disp_addr;
  logic              o_disp_gnt;
  logic [DATA_W-1:0] o_disp_rdata;
  logic              o_disp_rvalid;
  logic              i_cap_req;
  logic [ADDR_W-1:0] i_cap_addr;
  logic [DATA_W-1:0] i_cap_wdata;
  logic              o_cap_gnt;
  logic              i_pnt_req, i_pnt_we;
  logic [ADDR_W-1:0] i_pnt_addr;
  logic [DATA_W-1:0] i_pnt_wdata;
  logic              o_pnt_gnt;
  logic [DATA_W-1:0] o_pnt_rdata;
  logic              o_pnt_rvalid;

  sram_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sram_if ();

  sram_access_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .CAP_WORDS  (4),
    .STARVE_MAX (3)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_start_cap   (i_start_cap),
    .i_stop        (i_stop),
    .o_cap_done    (o_cap_done),
    .o_state       (o_state),
    .i_disp_req    (i_disp_req),
    .i_disp_addr   (i_disp_addr),
    .o_disp_gnt    (o_disp_gnt),
    .o_disp_rdata  (o_disp_rdata),
    .o_disp_rvalid (o_disp_rvalid),
    .i_cap_req     (i_cap_req),
    .i_cap_addr    (i_cap_addr),
    .i_cap_wdata   (i_cap_wdata),
    .o_cap_gnt     (o_cap_gnt),
    .i_pnt_req     (i_pnt_req),
    .i_pnt_we      (i_pnt_we),
    .i_pnt_addr    (i_pnt_addr),
    .i_pnt_wdata   (i_pnt_wdata),
    .o_pnt_gnt     (o_pnt_gnt),
    .o_pnt_rdata   (o_pnt_rdata),
    .o_pnt_rvalid  (o_pnt_rvalid),
    .sram          (sram_if)
  );

  // SRAM model: asynchronous read, write on the rising edge when wen is low.
  logic [DATA_W-1:0] mem [256];
  assign sram_if.i_s_data = mem[sram_if.o_s_addr[7:0]];
  always @(posedge i_clk) begin
    if (!i_rst_n) begin
      mem[8'h10] <= 16'h1234;
      mem[8'h20] <= 16'hBEEF;
    end else if (sram_if.o_s_wen == 1'b0) begin
      mem[sram_if.o_s_addr[7:0]] <= sram_if.o_s_data;
    end
  end

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // One record per cycle: inputs, then the outputs expected 1 ns after the
  // falling edge. Pin fields reflect the grant of the previous record.
  typedef struct packed {
    logic              start;
    logic              stop;
    logic              dreq;
    logic              creq;
    logic [ADDR_W-1:0] caddr;
    logic              preq;
    logic [2:0]        gnt;    // {disp, cap, pnt}
    logic              done;
    logic [1:0]        st;
    logic              wen;
    logic [ADDR_W-1:0] saddr;
    logic [DATA_W-1:0] sdata;
    logic [1:0]        rv;     // {disp, pnt}
  } vec_t;

  function automatic vec_t mk(int st_i, int sp_i, int dr_i, int cr_i, int ca_i, int pr_i,
                              int g_i, int dn_i, int s_i, int wen_i, int sa_i, int sd_i, int rv_i);
    vec_t v;
    v.start = st_i[0];
    v.stop  = sp_i[0];
    v.dreq  = dr_i[0];
    v.creq  = cr_i[0];
    v.caddr = ca_i[ADDR_W-1:0];
    v.preq  = pr_i[0];
    v.gnt   = g_i[2:0];
    v.done  = dn_i[0];
    v.st    = s_i[1:0];
    v.wen   = wen_i[0];
    v.saddr = sa_i[ADDR_W-1:0];
    v.sdata = sd_i[DATA_W-1:0];
    v.rv    = rv_i[1:0];
    return v;
  endfunction

  localparam int NV = 29;
  vec_t vecs [NV];

  task automatic clear_inputs();
    i_start_cap = 1'b0; i_stop = 1'b0;
    i_disp_req = 1'b0;  i_disp_addr = '0;
    i_cap_req = 1'b0;   i_cap_addr = '0; i_cap_wdata = '0;
    i_pnt_req = 1'b0;   i_pnt_we = 1'b0; i_pnt_addr = '0; i_pnt_wdata = '0;
  endtask

  initial begin
    //            st sp dr cr caddr pr  gnt done st wen saddr  sdata    rv
    vecs[0]  = mk(1, 0, 0, 0, 0,    0,  0,  0,  0, 1,  0,     0,       0);
    vecs[1]  = mk(0, 0, 0, 1, 0,    0,  2,  0,  1, 1,  0,     0,       0);
    vecs[2]  = mk(0, 0, 0, 1, 1,    0,  2,  0,  1, 0,  0,     'hA000,  0);
    vecs[3]  = mk(0, 0, 0, 1, 2,    0,  2,  0,  1, 0,  1,     'hA001,  0);
    vecs[4]  = mk(0, 0, 0, 1, 3,    0,  2,  1,  1, 0,  2,     'hA002,  0);
    vecs[5]  = mk(0, 0, 0, 0, 0,    0,  0,  0,  2, 0,  3,     'hA003,  0);
    vecs[6]  = mk(1, 0, 0, 0, 0,    0,  0,  0,  2, 1,  3,     'hA003,  0);
    vecs[7]  = mk(0, 0, 1, 1, 7,    0,  4,  0,  1, 1,  3,     'hA003,  0);
    vecs[8]  = mk(0, 0, 1, 1, 7,    0,  4,  0,  1, 1,  'h40,  'hA003,  0);
    vecs[9]  = mk(0, 0, 0, 1, 7,    0,  2,  0,  1, 1,  'h40,  'hA003,  2);
    vecs[10] = mk(0, 1, 0, 0, 0,    0,  0,  0,  1, 0,  7,     'hA007,  2);
    vecs[11] = mk(0, 0, 1, 1, 7,    1,  4,  0,  0, 1,  7,     'hA007,  0);
    vecs[12] = mk(1, 0, 0, 0, 0,    0,  0,  0,  0, 1,  'h40,  'hA007,  0);
    vecs[13] = mk(0, 0, 0, 1, 'h50, 0,  2,  0,  1, 1,  'h40,  'hA007,  2);
    vecs[14] = mk(0, 0, 0, 1, 'h51, 0,  2,  0,  1, 0,  'h50,  'hA050,  0);
    vecs[15] = mk(0, 0, 0, 1, 'h52, 0,  2,  0,  1, 0,  'h51,  'hA051,  0);
    vecs[16] = mk(0, 0, 0, 1, 'h53, 0,  2,  1,  1, 0,  'h52,  'hA052,  0);
    vecs[17] = mk(0, 0, 0, 0, 0,    0,  0,  0,  2, 0,  'h53,  'hA053,  0);
    vecs[18] = mk(0, 0, 1, 0, 0,    1,  4,  0,  2, 1,  'h53,  'hA053,  0);
    vecs[19] = mk(0, 0, 1, 0, 0,    1,  4,  0,  2, 1,  'h40,  'hA053,  0);
    vecs[20] = mk(0, 0, 1, 0, 0,    1,  4,  0,  2, 1,  'h40,  'hA053,  2);
    vecs[21] = mk(0, 0, 1, 0, 0,    1,  1,  0,  2, 1,  'h40,  'hA053,  2);
    vecs[22] = mk(0, 0, 1, 0, 0,    1,  4,  0,  2, 1,  'h60,  'hA053,  2);
    vecs[23] = mk(0, 0, 1, 0, 0,    1,  4,  0,  2, 1,  'h40,  'hA053,  1);
    vecs[24] = mk(0, 0, 1, 0, 0,    1,  4,  0,  2, 1,  'h40,  'hA053,  2);
    vecs[25] = mk(0, 0, 1, 0, 0,    1,  1,  0,  2, 1,  'h40,  'hA053,  2);
    vecs[26] = mk(0, 0, 0, 0, 0,    0,  0,  0,  2, 1,  'h60,  'hA053,  2);
    vecs[27] = mk(0, 0, 0, 0, 0,    0,  0,  0,  2, 1,  'h60,  'hA053,  1);
    vecs[28] = mk(0, 0, 0, 0, 0,    0,  0,  0,  2, 1,  'h60,  'hA053,  0);

    // ---------------- reset values ----------------
    clear_inputs();
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    #1;
    chk("rst.gnt",    32'({o_disp_gnt, o_cap_gnt, o_pnt_gnt}), 32'd0);
    chk("rst.state",  32'(o_state), 32'd0);
    chk("rst.done",   32'(o_cap_done), 32'd0);
    chk("rst.wen",    32'(sram_if.o_s_wen), 32'd1);
    chk("rst.saddr",  32'(sram_if.o_s_addr), 32'd0);
    chk("rst.sdata",  32'(sram_if.o_s_data), 32'd0);
    chk("rst.rvalid", 32'({o_disp_rvalid, o_pnt_rvalid}), 32'd0);
    chk("rst.rdata",  32'({o_disp_rdata, o_pnt_rdata}), 32'd0);
    i_rst_n = 1'b1;

    // ---------------- table-driven phase/priority/starvation run ----------------
    for (int k = 0; k < NV; k++) begin
      @(negedge i_clk);
      i_start_cap = vecs[k].start;
      i_stop      = vecs[k].stop;
      i_disp_req  = vecs[k].dreq;
      i_disp_addr = 20'h00040;
      i_cap_req   = vecs[k].creq;
      i_cap_addr  = vecs[k].caddr;
      i_cap_wdata = 16'hA000 + vecs[k].caddr[15:0];
      i_pnt_req   = vecs[k].preq;
      i_pnt_we    = 1'b0;
      i_pnt_addr  = 20'h00060;
      #1;
      chk($sformatf("v%0d.gnt", k),   32'({o_disp_gnt, o_cap_gnt, o_pnt_gnt}), 32'(vecs[k].gnt));
      chk($sformatf("v%0d.done", k),  32'(o_cap_done), 32'(vecs[k].done));
      chk($sformatf("v%0d.state", k), 32'(o_state), 32'(vecs[k].st));
      chk($sformatf("v%0d.wen", k),   32'(sram_if.o_s_wen), 32'(vecs[k].wen));
      chk($sformatf("v%0d.saddr", k), 32'(sram_if.o_s_addr), 32'(vecs[k].saddr));
      chk($sformatf("v%0d.sdata", k), 32'(sram_if.o_s_data), 32'(vecs[k].sdata));
      chk($sformatf("v%0d.rvalid", k), 32'({o_disp_rvalid, o_pnt_rvalid}), 32'(vecs[k].rv));
    end

    // ---------------- painter write -> read turnaround (in PAINT) ----------------
    @(negedge i_clk);
    clear_inputs();
    i_pnt_req = 1'b1; i_pnt_we = 1'b1; i_pnt_addr = 20'h00030; i_pnt_wdata = 16'h5555;
    #1;
    chk("ta.wr_gnt", 32'(o_pnt_gnt), 32'd1);
    @(negedge i_clk);
    i_pnt_we = 1'b0; i_pnt_addr = 20'h00010;
    #1;
    chk("ta.bubble_gnt", 32'(o_pnt_gnt), 32'd0);
    chk("ta.wr_wen",     32'(sram_if.o_s_wen), 32'd0);
    chk("ta.wr_addr",    32'(sram_if.o_s_addr), 32'h30);
    chk("ta.wr_data",    32'(sram_if.o_s_data), 32'h5555);
    @(negedge i_clk);
    #1;
    chk("ta.rd_gnt", 32'(o_pnt_gnt), 32'd1);
    @(negedge i_clk);
    i_pnt_req = 1'b0;
    #1;
    chk("ta.rd_wen",    32'(sram_if.o_s_wen), 32'd1);
    chk("ta.rd_addr",   32'(sram_if.o_s_addr), 32'h10);
    chk("ta.rv_early",  32'(o_pnt_rvalid), 32'd0);
    @(negedge i_clk);
    #1;
    chk("ta.rvalid", 32'(o_pnt_rvalid), 32'd1);
    chk("ta.rdata",  32'(o_pnt_rdata), 32'h1234);
    chk("ta.disp_rv", 32'(o_disp_rvalid), 32'd0);
    @(negedge i_clk);
    #1;
    chk("ta.rv_drop", 32'(o_pnt_rvalid), 32'd0);

    // ---------------- reset with a display read in flight ----------------
    @(negedge i_clk);
    i_disp_req = 1'b1; i_disp_addr = 20'h00020;
    #1;
    chk("rr.gnt", 32'(o_disp_gnt), 32'd1);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    chk("rr.gnt_in_rst", 32'(o_disp_gnt), 32'd0);
    chk("rr.wen",        32'(sram_if.o_s_wen), 32'd1);
    chk("rr.saddr",      32'(sram_if.o_s_addr), 32'd0);
    chk("rr.sdata",      32'(sram_if.o_s_data), 32'd0);
    chk("rr.state",      32'(o_state), 32'd0);
    chk("rr.rdata",      32'({o_disp_rdata, o_pnt_rdata}), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      i_disp_req = 1'b0;
      i_rst_n    = 1'b1;
      #1;
      chk($sformatf("rr.no_rv%0d", c), 32'(o_disp_rvalid), 32'd0);
    end

    // ---------------- simultaneous start/stop in PAINT ----------------
    @(negedge i_clk);
    i_start_cap = 1'b1;
    @(negedge i_clk);
    i_start_cap = 1'b0;
    for (int n = 0; n < 4; n++) begin
      i_cap_req  = 1'b1;
      i_cap_addr = 20'h00070 + ADDR_W'(n);
      #1;
      chk($sformatf("ss.fill_done%0d", n), 32'(o_cap_done), (n == 3) ? 32'd1 : 32'd0);
      @(negedge i_clk);
    end
    i_cap_req = 1'b0;
    #1;
    chk("ss.in_paint", 32'(o_state), 32'd2);
    @(negedge i_clk);
    i_start_cap = 1'b1; i_stop = 1'b1;
    i_pnt_req = 1'b1; i_pnt_we = 1'b0; i_pnt_addr = 20'h00020;
    #1;
    chk("ss.pnt_gnt", 32'(o_pnt_gnt), 32'd1);
    @(negedge i_clk);
    clear_inputs();
    #1;
    chk("ss.state", 32'(o_state), 32'd1);
    chk("ss.rv_t1", 32'(o_pnt_rvalid), 32'd0);
    for (int n = 0; n < 4; n++) begin
      @(negedge i_clk);
      i_cap_req  = 1'b1;
      i_cap_addr = 20'h00080 + ADDR_W'(n);
      #1;
      if (n == 0) begin
        chk("ss.rv_t2",  32'(o_pnt_rvalid), 32'd1);
        chk("ss.rdata",  32'(o_pnt_rdata), 32'hBEEF);
      end
      chk($sformatf("ss.cap_gnt%0d", n),  32'(o_cap_gnt), 32'd1);
      chk($sformatf("ss.cap_done%0d", n), 32'(o_cap_done), (n == 3) ? 32'd1 : 32'd0);
    end
    @(negedge i_clk);
    clear_inputs();
    #1;
    chk("ss.back_paint", 32'(o_state), 32'd2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_access_arbiter.md
Name: sram_access_arbiter

Overview:
- Shares the single-port 16-bit external SRAM between three clients: display read-back (real-time), frame-region capture writer, and painter engine (brush-stroke read/modify/write).
- Sits between the top-level capture/display control and the SRAM pins.
- Sequences capture → paint phases.
- Issues one access per clock and inserts write→read bus turnaround.
- Guarantees painter forward progress with a starvation override.

Parameters:
- ADDR_W, 20, SRAM word address width
- DATA_W, 16, SRAM data width
- CAP_WORDS, 105000, number of capture writes per frame (350x300 region)
- STARVE_MAX, 15, consecutive denied painter cycles before one forced painter grant; 0 disables the override

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_start_cap  in  1  pulse: begin capture phase
- i_stop  in  1  pulse: return to idle
- o_cap_done  out  1  one-cycle pulse when CAP_WORDS writes have issued
- o_state  out  2  current phase (IDLE=0, CAPTURE=1, PAINT=2)
- i_disp_req  in  1  display read request, held until granted
- i_disp_addr  in  ADDR_W  display read address
- o_disp_gnt  out  1  display granted this cycle
- o_disp_rdata  out  DATA_W  display read data
- o_disp_rvalid  out  1  display read data valid
- i_cap_req  in  1  capture write request
- i_cap_addr  in  ADDR_W  capture write address
- i_cap_wdata  in  DATA_W  capture write data
- o_cap_gnt  out  1  capture granted this cycle
- i_pnt_req  in  1  painter request
- i_pnt_we  in  1  painter write (1) / read (0)
- i_pnt_addr  in  ADDR_W  painter address
- i_pnt_wdata  in  DATA_W  painter write data
- o_pnt_gnt  out  1  painter granted this cycle
- o_pnt_rdata  out  DATA_W  painter read data
- o_pnt_rvalid  out  1  painter read data valid
- o_s_addr  out  ADDR_W  SRAM address, registered
- o_s_data  out  DATA_W  SRAM write data, registered
- o_s_wen  out  1  SRAM write enable, active low, registered
- i_s_data  in  DATA_W  SRAM read data

Behaviour:
- Reset (async, active low) values:
  - o_s_wen=1; o_s_addr=0; o_s_data=0.
  - All gnt, rvalid and o_cap_done = 0; all rdata = 0.
  - State=IDLE; capture counter=0; starvation counter=0; last-issue-was-write flag=0.
- Grants are combinational from the current requests and registered state; at most one gnt per cycle. A client holds req/addr/wdata stable until its gnt.
- Issue timing:
  - Grant in cycle t → o_s_addr/o_s_data/o_s_wen valid in cycle t+1.
  - Read: i_s_data is sampled at the end of t+1; matching rdata/rvalid are high for one cycle at t+2.
  - Ungranted cycles drive o_s_wen=1, with address and data held.
- Turnaround: if the access issued in the previous cycle was a write and the winning candidate is a read, no grant is given this cycle (one bubble). The candidate wins next cycle if still highest priority. Write→write and read→write need no bubble.
- States:
  - IDLE: only display is served. i_start_cap → CAPTURE.
  - CAPTURE: priority display > capture; painter never granted. Each capture grant increments the counter. The grant that makes count==CAP_WORDS pulses o_cap_done in the same cycle, clears the counter and moves to PAINT next cycle. i_stop → IDLE (counter cleared).
  - PAINT: priority display > painter, capture never granted.
    - Starvation counter increments each cycle i_pnt_req=1 and not granted; it clears on painter grant or when req is low.
    - When counter==STARVE_MAX (STARVE_MAX>0), the painter beats display for that cycle. Display simply waits.
    - i_start_cap → CAPTURE (counter cleared); i_stop → IDLE.
- Simultaneous i_start_cap and i_stop: i_start_cap wins.
- State changes take effect the next cycle. Reads already in flight still return rvalid to their owner.
- Reset mid-operation drops in-flight reads (no rvalid after reset).
- The capture counter is ADDR_W bits wide; it never wraps because it is cleared at CAP_WORDS.

Decomposition:
- Package sram_arb_pkg holds:
  - arb_state_t enum (S_IDLE, S_CAPTURE, S_PAINT).
  - Client id enum (CL_NONE, CL_DISP, CL_CAP, CL_PNT).
  - Constants SRAM_WEN_WRITE=0 and SRAM_WEN_IDLE=1.
- One sub-module, sram_issue_pipe, holds:
  - The registered SRAM pin stage.
  - The 2-stage read-return pipeline carrying the client id, which steers rdata/rvalid.

Test Plan:
- Reset, then CAPTURE with CAP_WORDS=4 and i_cap_req held (addr 0..3, data 0xA000+n), disp idle → four consecutive gnts; o_s_wen=0 with addresses 0..3 on cycles t+1; o_cap_done on the 4th gnt; o_state=PAINT next cycle.
- CAPTURE with both disp and cap requesting every cycle → disp granted every cycle, cap never; drop disp_req → cap granted the same cycle.
- PAINT: painter write granted at t, then painter read (addr 0x00010, SRAM returns 0x1234) requested at t+1 → no gnt at t+1 (bubble); gnt at t+2; o_pnt_rdata=0x1234 with rvalid at t+4.
- PAINT, STARVE_MAX=3, disp and pnt requesting continuously → pnt granted on the 4th cycle only, then the pattern repeats (3 disp, 1 pnt).
- Display read (addr 0x00020, data 0xBEEF) granted, then i_rst_n asserted at t+1 → all outputs at reset values immediately, no rvalid afterwards.
- i_start_cap and i_stop pulsed together in PAINT → state CAPTURE next cycle; capture counter=0; a painter read granted in the same cycle still returns o_pnt_rvalid at t+2.
